// File: rtl/pet_memmap_if.sv
// pet_memmap_if: CPU bus and DMA request port of the PET memory map.
// master drives the requests; slave is the memory-map controller.
interface pet_memmap_if;
    logic        ce_1m;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        dma_req;
    logic [14:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        dma_ack;
    logic [7:0]  dma_dout;

    modport master (
        output ce_1m, addr, we, data_in,
        output dma_req, dma_addr, dma_din, dma_we,
        input  data_out, dma_ack, dma_dout
    );

    modport slave (
        input  ce_1m, addr, we, data_in,
        input  dma_req, dma_addr, dma_din, dma_we,
        output data_out, dma_ack, dma_dout
    );
endinterface

// File: rtl/pet_memmap.sv
// pet_memmap: PET CPU address decode, registered read mux and RAM DMA arbiter.
// Define PET_BANK8096_EN for the 8096 bank/control register at $FFF0.
module pet_memmap #(
    parameter int         RAM_KB       = 32,
    parameter int         VRAM_KB      = 2,
    parameter logic [7:0] UNMAPPED_VAL = 8'h55
) (
    input  logic        clk,
    input  logic        reset_n,
    pet_memmap_if.slave bus,
    input  logic [7:0]  ram_q,
    input  logic [7:0]  vram_q,
    input  logic [7:0]  rom_q,
    input  logic [7:0]  io_q,
    input  logic [7:0]  exram_q,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        vram_we,
    output logic        io_we,
    output logic        exram_we,
    output logic [15:0] exram_addr,
    output logic [7:0]  ctrl_q
);
    typedef enum logic [2:0] {
        R_NONE, R_RAM, R_VRAM, R_ROM, R_IO, R_EXRAM
    } region_t;

    typedef enum logic [1:0] {
        IDLE, DMA_ACC, DMA_RD, DMA_ACK
    } dma_state_t;

    // a 1 KB VRAM is mirrored across the full 2 KB window
    localparam int          VRAM_WIN = (VRAM_KB == 1) ? 2 : VRAM_KB;
    localparam logic [16:0] RAM_TOP  = 17'(RAM_KB * 1024);
    localparam logic [16:0] VRAM_TOP = 17'(32768 + VRAM_WIN * 1024);

    region_t    region, rsel;
    dma_state_t state, state_nx;
    logic [7:0] ctrl;
    logic [7:0] rd_mux, dout, dma_q;
    logic       rd_pend;
    logic       cpu_wr, dma_own;
    logic       ram_hit, vram_hit, io_hit, rom_hit;

    assign cpu_wr   = bus.ce_1m & bus.we;
    assign ram_hit  = {1'b0, bus.addr} < RAM_TOP;
    assign vram_hit = bus.addr[15] && ({1'b0, bus.addr} < VRAM_TOP);
    assign io_hit   = bus.addr[15:11] == 5'b11101;
    assign rom_hit  = (bus.addr >= 16'hB000) && !io_hit;

    always_comb begin
        region = R_NONE;
        unique case (1'b1)
            ram_hit:  region = R_RAM;
            vram_hit: region = R_VRAM;
            io_hit:   region = R_IO;
            rom_hit:  region = R_ROM;
            default:  ;
        endcase
`ifdef PET_BANK8096_EN
        if (ctrl[7] && bus.addr[15]) begin
            region = R_EXRAM;
            if (ctrl[5] && bus.addr[15:12] == 4'h8)
                region = R_VRAM;
            if (ctrl[6] && io_hit)
                region = R_IO;
        end
`endif
    end

`ifdef PET_BANK8096_EN
    logic wp;

    assign wp = bus.addr[14] ? ctrl[1] : ctrl[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ctrl <= 8'h00;
        else if (cpu_wr && bus.addr == 16'hFFF0)
            ctrl <= bus.data_in;
    end

    assign exram_we   = cpu_wr && region == R_EXRAM && !wp;
    assign exram_addr = {bus.addr[14],
                         bus.addr[14] ? ctrl[3] : ctrl[2],
                         bus.addr[13:0]};
`else
    assign ctrl       = 8'h00;
    assign exram_we   = 1'b0;
    assign exram_addr = 16'h0000;
`endif

    assign ctrl_q = ctrl;

    // the CPU keeps the RAM port whenever ce_1m is high
    assign dma_own  = state == DMA_ACC && !bus.ce_1m;
    assign mem_addr = dma_own ? bus.dma_addr : bus.addr[14:0];
    assign mem_din  = dma_own ? bus.dma_din : bus.data_in;
    assign mem_we   = dma_own ? bus.dma_we
                              : cpu_wr && region == R_RAM;
    assign vram_we  = cpu_wr && region == R_VRAM;
    assign io_we    = cpu_wr && region == R_IO;

    always_comb begin
        unique case (rsel)
            R_RAM:   rd_mux = ram_q;
            R_VRAM:  rd_mux = vram_q;
            R_ROM:   rd_mux = rom_q;
            R_IO:    rd_mux = io_q;
            R_EXRAM: rd_mux = exram_q;
            default: rd_mux = UNMAPPED_VAL;
        endcase
    end

    // q of the block is valid one clk after the access edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsel    <= R_NONE;
            rd_pend <= 1'b0;
            dout    <= UNMAPPED_VAL;
        end else begin
            rd_pend <= bus.ce_1m;
            if (bus.ce_1m)
                rsel <= region;
            if (rd_pend)
                dout <= rd_mux;
        end
    end

    assign bus.data_out = dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dma_q <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == DMA_RD)
                dma_q <= ram_q;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.dma_req && !bus.ce_1m)
                         state_nx = DMA_ACC;
            DMA_ACC: state_nx = bus.dma_we ? DMA_ACK : DMA_RD;
            DMA_RD:  state_nx = DMA_ACK;
            DMA_ACK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.dma_ack  = state == DMA_ACK;
    assign bus.dma_dout = dma_q;
endmodule

// File: tb/tb_pet_memmap.sv
// tb_pet_memmap: scoreboard bench for pet_memmap with RAM_KB=16.
// Banking checks run when PET_BANK8096_EN is defined.
module tb_pet_memmap;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  ram_q, vram_q, rom_q, io_q, exram_q;
    logic [14:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, vram_we, io_we, exram_we;
    logic [15:0] exram_addr;
    logic [7:0]  ctrl_q;

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic [7:0] sb[$];

    logic [7:0] ram   [0:32767];
    logic [7:0] vram  [0:2047];
    logic [7:0] exram [0:65535];

    pet_memmap_if bus ();

    pet_memmap #(
        .RAM_KB(16),
        .VRAM_KB(2),
        .UNMAPPED_VAL(8'h55)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .ram_q(ram_q),
        .vram_q(vram_q),
        .rom_q(rom_q),
        .io_q(io_q),
        .exram_q(exram_q),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_we(mem_we),
        .vram_we(vram_we),
        .io_we(io_we),
        .exram_we(exram_we),
        .exram_addr(exram_addr),
        .ctrl_q(ctrl_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        return a[15:8] ^ a[7:0];
    endfunction

    function automatic logic [7:0] io_val(input logic [15:0] a);
        return {a[3:0], 4'h9};
    endfunction

    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_din;
        ram_q <= ram[mem_addr];
        if (vram_we)
            vram[bus.addr[10:0]] <= bus.data_in;
        vram_q <= vram[bus.addr[10:0]];
        rom_q <= rom_val(bus.addr);
        io_q  <= io_val(bus.addr);
        if (exram_we)
            exram[exram_addr] <= bus.data_in;
        exram_q <= exram[exram_addr];
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (mon_en && bus.ce_1m) begin
            check("cpu_owns_we", 16'(mem_we), 16'd0);
            check("cpu_owns_addr", 16'(mem_addr), 16'(bus.addr[14:0]));
        end
    end

    task automatic cpu_write(input string tag, input logic [15:0] a,
                             input logic [7:0] d, input logic [3:0] exp_stb);
        @(negedge clk);
        bus.ce_1m = 1'b1;
        bus.addr = a;
        bus.we = 1'b1;
        bus.data_in = d;
        #1;
        check(tag, 16'({mem_we, vram_we, io_we, exram_we}), 16'(exp_stb));
        @(negedge clk);
        bus.ce_1m = 1'b0;
        bus.we = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] a,
                            input logic [7:0] exp);
        logic [7:0] e;
        sb.push_back(exp);
        @(negedge clk);
        bus.ce_1m = 1'b1;
        bus.addr = a;
        bus.we = 1'b0;
        @(negedge clk);
        bus.ce_1m = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        check(tag, 16'(bus.data_out), 16'(e));
        @(negedge clk);
    endtask

    task automatic ce_gen(input int frames);
        for (int f = 0; f < frames; f++) begin
            @(negedge clk);
            bus.ce_1m = 1'b1;
            bus.addr = 16'h2000;
            bus.we = 1'b0;
            @(negedge clk);
            bus.ce_1m = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic dma_run(input logic [14:0] a, input logic w,
                           input logic [7:0] d, input int exp_lat);
        int lat;
        bit hit;
        logic [7:0] e;
        @(negedge clk);
        bus.dma_req = 1'b1;
        bus.dma_addr = a;
        bus.dma_we = w;
        bus.dma_din = d;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            hit = !bus.ce_1m;
        end
        check("dma_grant", 16'(hit), 16'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.dma_ack && lat < 20);
        check(w ? "dma_wr_lat" : "dma_rd_lat", 16'(lat), 16'(exp_lat));
        if (!w) begin
            e = sb.pop_front();
            check("dma_dout", 16'(bus.dma_dout), 16'(e));
        end
        bus.dma_req = 1'b0;
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 65536; i++)
            exram[i] = 8'(i) ^ 8'h5A;
        reset_n = 1'b0;
        bus.ce_1m = 1'b0;
        bus.addr = 16'h0000;
        bus.we = 1'b0;
        bus.data_in = 8'h00;
        bus.dma_req = 1'b0;
        bus.dma_addr = 15'h0000;
        bus.dma_din = 8'h00;
        bus.dma_we = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_data_out", 16'(bus.data_out), 16'h0055);
        check("rst_ctrl", 16'(ctrl_q), 16'h0000);
        check("rst_ack", 16'(bus.dma_ack), 16'd0);
        check("rst_dma_dout", 16'(bus.dma_dout), 16'h0000);
        check("rst_strobes",
              16'({mem_we, vram_we, io_we, exram_we}), 16'd0);

        cpu_write("wr_ram_top", 16'h3FFF, 8'hA5, 4'b1000);
        cpu_read("rd_ram_top", 16'h3FFF, 8'hA5);
        cpu_read("rd_above_ram", 16'h4000, 8'h55);
        cpu_write("wr_vram", 16'h8000, 8'h3C, 4'b0100);
        cpu_read("rd_vram", 16'h8000, 8'h3C);
        cpu_read("rd_rom_c000", 16'hC000, rom_val(16'hC000));
        cpu_read("rd_io", 16'hE810, io_val(16'hE810));
        cpu_write("wr_io", 16'hE810, 8'h12, 4'b0010);
        cpu_write("wr_rom", 16'hC000, 8'h77, 4'b0000);
        cpu_read("rd_unmapped", 16'h9000, 8'h55);

        cpu_write("wr_ctrl80", 16'hFFF0, 8'h80, 4'b0000);
`ifdef PET_BANK8096_EN
        check("ctrl80", 16'(ctrl_q), 16'h0080);
        cpu_read("rd_bank_c000", 16'hC000, 8'h00 ^ 8'h5A);
        cpu_write("wr_ctrl84", 16'hFFF0, 8'h84, 4'b0001);
        cpu_write("wr_ex_9000", 16'h9000, 8'h11, 4'b0001);
        bus.addr = 16'h9000;
        #1;
        check("exram_addr", exram_addr, 16'h5000);
        cpu_read("rd_ex_9000", 16'h9000, 8'h11);
        cpu_write("wr_ctrle5", 16'hFFF0, 8'hE5, 4'b0001);
        check("ctrle5", 16'(ctrl_q), 16'h00E5);
        cpu_write("wr_peek_8010", 16'h8010, 8'h22, 4'b0100);
        cpu_write("wr_prot_a000", 16'hA000, 8'h33, 4'b0000);
        cpu_write("wr_io_thru", 16'hE820, 8'h44, 4'b0010);
`else
        check("ctrl_none", 16'(ctrl_q), 16'h0000);
        cpu_read("rd_rom_nobank", 16'hC000, rom_val(16'hC000));
        cpu_write("wr_9000_none", 16'h9000, 8'h11, 4'b0000);
        bus.addr = 16'h9000;
        #1;
        check("exram_addr0", exram_addr, 16'h0000);
`endif

        cpu_write("wr_ram_0100", 16'h0100, 8'h7E, 4'b1000);
        mon_en = 1'b1;
        sb.push_back(8'h7E);
        fork
            ce_gen(4);
            dma_run(15'h0100, 1'b0, 8'h00, 3);
        join
        fork
            ce_gen(2);
            dma_run(15'h0200, 1'b1, 8'h9A, 2);
        join
        mon_en = 1'b0;
        cpu_read("rd_dma_wr", 16'h0200, 8'h9A);

        @(negedge clk);
        bus.dma_req = 1'b1;
        bus.dma_addr = 15'h0100;
        bus.dma_we = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        bus.dma_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2)
                reset_n = 1'b1;
            @(negedge clk);
            acks += int'(bus.dma_ack);
        end
        check("rst_no_ack", 16'(acks), 16'd0);
        check("rst_dma_dout2", 16'(bus.dma_dout), 16'h0000);
        check("rst_ctrl2", 16'(ctrl_q), 16'h0000);
        check("rst_data_out2", 16'(bus.data_out), 16'h0055);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
